// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI-flash command sequencer: operation codes, flash opcodes,
// frame lengths, FSM state types and the frame builders.
package spi_flash_pkg;

   localparam logic [2:0] OP_READ_ID = 3'd0;
   localparam logic [2:0] OP_READ    = 3'd1;
   localparam logic [2:0] OP_PROG    = 3'd2;
   localparam logic [2:0] OP_ERASE   = 3'd3;
   localparam logic [2:0] OP_RDSR    = 3'd4;

   localparam logic [7:0] CMD_RDID = 8'h9F;
   localparam logic [7:0] CMD_READ = 8'h03;
   localparam logic [7:0] CMD_PP   = 8'h02;
   localparam logic [7:0] CMD_SE   = 8'h20;
   localparam logic [7:0] CMD_RDSR = 8'h05;
   localparam logic [7:0] CMD_WREN = 8'h06;

   localparam logic [7:0] LEN_RDID = 8'd32;
   localparam logic [7:0] LEN_READ = 8'd40;
   localparam logic [7:0] LEN_PP   = 8'd40;
   localparam logic [7:0] LEN_SE   = 8'd32;
   localparam logic [7:0] LEN_RDSR = 8'd16;
   localparam logic [7:0] LEN_WREN = 8'd8;

   typedef enum logic [2:0] {StIdle, StWren, StCmd, StPoll, StGap, StFin} cmd_state_e;
   typedef enum logic [1:0] {XfIdle, XfWaitAct, XfWaitDone} xfer_state_e;

   typedef struct packed {
      logic [7:0]   len;
      logic [127:0] data;
   } frame_t;

   function automatic logic op_valid(input logic [2:0] op);
      return op <= OP_RDSR;
   endfunction

   // Program and erase need a write-enable frame first.
   function automatic logic needs_wren(input logic [2:0] op);
      return (op == OP_PROG) || (op == OP_ERASE);
   endfunction

   // Right-aligned command frame; bits above len stay zero.
   function automatic frame_t cmd_frame(input logic [2:0] op, input logic [23:0] addr,
                                        input logic [7:0] wdata);
      frame_t f;
      f = '0;
      case (op)
         OP_READ_ID: begin
            f.len        = LEN_RDID;
            f.data[31:0] = {CMD_RDID, 24'h000000};
         end
         OP_READ: begin
            f.len        = LEN_READ;
            f.data[39:0] = {CMD_READ, addr, 8'h00};
         end
         OP_PROG: begin
            f.len        = LEN_PP;
            f.data[39:0] = {CMD_PP, addr, wdata};
         end
         OP_ERASE: begin
            f.len        = LEN_SE;
            f.data[31:0] = {CMD_SE, addr};
         end
         OP_RDSR: begin
            f.len        = LEN_RDSR;
            f.data[15:0] = {CMD_RDSR, 8'h00};
         end
         default: ;
      endcase
      return f;
   endfunction

   function automatic frame_t wren_frame();
      frame_t f;
      f           = '0;
      f.len       = LEN_WREN;
      f.data[7:0] = CMD_WREN;
      return f;
   endfunction

endpackage

// File: rtl/spi_flash_xfer.sv
// One shift-engine transfer: launch pulse, wait for busy to rise (with timeout), wait for busy
// to fall. xfer_done/xfer_err are combinational pulses in the cycle the transfer ends so the
// caller can chain the next frame back-to-back.
module spi_flash_xfer
   import spi_flash_pkg::*;
#(
   parameter int unsigned ACT_TIMEOUT = 16
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         go,
   input  logic [7:0]   len,
   input  logic [127:0] data,
   input  logic         eng_busy,
   input  logic [127:0] eng_rdata,
   output logic         eng_start,
   output logic [7:0]   eng_len,
   output logic [127:0] eng_data,
   output logic         xfer_done,
   output logic         xfer_err,
   output logic [23:0]  xfer_rdata
);

   localparam int unsigned CntW = $clog2(ACT_TIMEOUT + 1);

   xfer_state_e     state_q;
   logic [CntW-1:0] act_cnt_q;
   logic            unused_rdata;

   assign xfer_done    = (state_q == XfWaitDone) && !eng_busy;
   assign xfer_err     = (state_q == XfWaitAct) && !eng_busy &&
                         (act_cnt_q == CntW'(ACT_TIMEOUT - 1));
   assign xfer_rdata   = eng_rdata[23:0];
   assign unused_rdata = ^eng_rdata[127:24];

   // Transfer handshake; the frame registers hold until the next launch.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q   <= XfIdle;
         act_cnt_q <= '0;
         eng_start <= 1'b0;
         eng_len   <= '0;
         eng_data  <= '0;
      end else begin
         eng_start <= 1'b0;
         case (state_q)
            XfWaitAct: begin
               // Busy seen in the launch cycle already counts as activity.
               if (eng_busy)      state_q <= XfWaitDone;
               else if (xfer_err) state_q <= XfIdle;
               else               act_cnt_q <= act_cnt_q + 1'b1;
            end
            XfWaitDone: if (!eng_busy) state_q <= XfIdle;
            default: ;
         endcase
         if (go) begin
            state_q   <= XfWaitAct;
            act_cnt_q <= '0;
            eng_start <= 1'b1;
            eng_len   <= len;
            eng_data  <= data;
         end
      end
   end

endmodule

// File: rtl/spi_flash_cmd.sv
// SPI-flash command sequencer: turns high-level operations into shift-engine frames, inserts
// WREN ahead of program/erase and returns the extracted result.
// Build option: define SPI_FLASH_WIP_POLL_EN to poll RDSR until WIP clears after program/erase.
module spi_flash_cmd
   import spi_flash_pkg::*;
#(
   parameter int unsigned ACT_TIMEOUT = 16
`ifdef SPI_FLASH_WIP_POLL_EN
   ,
   parameter int unsigned POLL_MAX = 65535,
   parameter int unsigned POLL_GAP = 8
`endif
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_op,
   input  logic [23:0]  req_addr,
   input  logic [7:0]   req_wdata,
   output logic         done,
   output logic         err,
   output logic [23:0]  rdata,
   output logic         eng_start,
   output logic [7:0]   eng_len,
   output logic [127:0] eng_data,
   input  logic [127:0] eng_rdata,
   input  logic         eng_busy
);

   cmd_state_e  state_q;
   logic [2:0]  op_q;
   logic [23:0] addr_q;
   logic [7:0]  wdata_q;
   logic        accept;
   logic        go;
   frame_t      frame;
   logic        xfer_done;
   logic        xfer_err;
   logic [23:0] xfer_rdata;

`ifdef SPI_FLASH_WIP_POLL_EN
   localparam int unsigned PollW = $clog2(POLL_MAX + 1);
   localparam int unsigned GapW  = $clog2(POLL_GAP + 1);
   logic [PollW-1:0] poll_cnt_q;
   logic [GapW-1:0]  gap_cnt_q;
`endif

   // Ready only in idle with the engine quiet, so an aborted frame drains first.
   assign req_ready = rst_n && (state_q == StIdle) && !eng_busy;
   assign accept    = req_valid && req_ready;

   // Select the next frame and launch it in the same edge the previous step completes.
   always_comb begin
      go    = 1'b0;
      frame = '0;
      case (state_q)
         StIdle: begin
            if (accept && op_valid(req_op)) begin
               go    = 1'b1;
               frame = needs_wren(req_op) ? wren_frame()
                                          : cmd_frame(req_op, req_addr, req_wdata);
            end
         end
         StWren: begin
            if (xfer_done) begin
               go    = 1'b1;
               frame = cmd_frame(op_q, addr_q, wdata_q);
            end
         end
`ifdef SPI_FLASH_WIP_POLL_EN
         StCmd: begin
            if (xfer_done && needs_wren(op_q)) begin
               go    = 1'b1;
               frame = cmd_frame(OP_RDSR, 24'h0, 8'h0);
            end
         end
         StGap: begin
            if (gap_cnt_q == GapW'(POLL_GAP - 1)) begin
               go    = 1'b1;
               frame = cmd_frame(OP_RDSR, 24'h0, 8'h0);
            end
         end
`endif
         default: ;
      endcase
   end

   // Operation sequencing with registered done/err/rdata.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
`ifdef SPI_FLASH_WIP_POLL_EN
         poll_cnt_q <= '0;
         gap_cnt_q  <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  op_q    <= req_op;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (!op_valid(req_op)) begin
                     state_q <= StFin;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else if (needs_wren(req_op)) begin
                     state_q <= StWren;
                  end else begin
                     state_q <= StCmd;
                  end
               end
            end
            StWren: begin
               if (xfer_err) begin
                  state_q <= StFin;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else if (xfer_done) begin
                  state_q <= StCmd;
               end
            end
            StCmd: begin
               if (xfer_err) begin
                  state_q <= StFin;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else if (xfer_done) begin
                  if (needs_wren(op_q)) begin
`ifdef SPI_FLASH_WIP_POLL_EN
                     state_q    <= StPoll;
                     poll_cnt_q <= '0;
`else
                     state_q <= StFin;
                     done    <= 1'b1;
                     rdata   <= '0;
`endif
                  end else begin
                     state_q <= StFin;
                     done    <= 1'b1;
                     rdata   <= (op_q == OP_READ_ID) ? xfer_rdata : {16'h0, xfer_rdata[7:0]};
                  end
               end
            end
`ifdef SPI_FLASH_WIP_POLL_EN
            StPoll: begin
               if (xfer_err) begin
                  state_q <= StFin;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else if (xfer_done) begin
                  if (!xfer_rdata[0]) begin
                     state_q <= StFin;
                     done    <= 1'b1;
                     rdata   <= {16'h0, xfer_rdata[7:0]};
                  end else if (poll_cnt_q == PollW'(POLL_MAX - 1)) begin
                     state_q <= StFin;
                     done    <= 1'b1;
                     err     <= 1'b1;
                  end else begin
                     poll_cnt_q <= poll_cnt_q + 1'b1;
                     gap_cnt_q  <= '0;
                     state_q    <= StGap;
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == GapW'(POLL_GAP - 1)) state_q <= StPoll;
               else                                  gap_cnt_q <= gap_cnt_q + 1'b1;
            end
`endif
            StFin:   state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   spi_flash_xfer #(
      .ACT_TIMEOUT(ACT_TIMEOUT)
   ) u_xfer (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .go        (go),
      .len       (frame.len),
      .data      (frame.data),
      .eng_busy  (eng_busy),
      .eng_rdata (eng_rdata),
      .eng_start (eng_start),
      .eng_len   (eng_len),
      .eng_data  (eng_data),
      .xfer_done (xfer_done),
      .xfer_err  (xfer_err),
      .xfer_rdata(xfer_rdata)
   );

endmodule
